// File: rtl/size_field_patcher.sv
// size_field_patcher
// Collects back-patch requests for encoded size fields (one slot per requester)
// and writes each granted field into the bitstream buffer as big-endian bytes
// over a byte-wide valid/ready write port. Lowest requester index wins.
module size_field_patcher #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_offset_addr,
  input  logic [NUM_REQ*32-1:0]     req_val,
  input  logic [NUM_REQ*3-1:0]      req_byte_size,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      patch_done,
  output logic [CNT_W-1:0]          patch_count,
  output logic                      err_size
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [1:0]           k_q, k_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;

  logic [ADDR_W-1:0]    slot_addr_q [NUM_REQ];
  logic [ADDR_W-1:0]    slot_addr_d [NUM_REQ];
  logic [31:0]          slot_val_q  [NUM_REQ];
  logic [31:0]          slot_val_d  [NUM_REQ];
  logic [2:0]           slot_size_q [NUM_REQ];
  logic [2:0]           slot_size_d [NUM_REQ];

  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [31:0]          wval_q, wval_d;
  logic [2:0]           wsize_q, wsize_d;

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [2:0]           byte_sel;
  logic                 last_byte;

  // Fixed-priority pick: scanning downward leaves the lowest pending index.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Byte k of an n-byte field is value byte n-1-k (MSB first).
  assign byte_sel  = wsize_q - 3'd1 - {1'b0, k_q};
  assign last_byte = ({1'b0, k_q} == (wsize_q - 3'd1));

  // Slot capture, grant and write-sequencing next-state logic.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    k_d         = k_q;
    count_d     = count_q;
    err_d       = err_q;
    slot_addr_d = slot_addr_q;
    slot_val_d  = slot_val_q;
    slot_size_d = slot_size_q;
    waddr_d     = waddr_q;
    wval_d      = wval_q;
    wsize_d     = wsize_q;

    // Empty slots accept; illegal sizes are swallowed and flagged.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !pending_q[i]) begin
        if (req_byte_size[i*3 +: 3] inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
          pending_d[i]   = 1'b1;
          slot_addr_d[i] = req_offset_addr[i*ADDR_W +: ADDR_W];
          slot_val_d[i]  = req_val[i*32 +: 32];
          slot_size_d[i] = req_byte_size[i*3 +: 3];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          pending_d[grant_idx] = 1'b0;
          waddr_d = slot_addr_q[grant_idx];
          wval_d  = slot_val_q[grant_idx];
          wsize_d = slot_size_q[grant_idx];
          k_d     = 2'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (last_byte) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      DONE: begin
        count_d = count_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any field in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      k_q       <= 2'd0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      k_q       <= k_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // Slot and working payload; only meaningful while qualified by control state.
  always_ff @(posedge clock) begin
    slot_addr_q <= slot_addr_d;
    slot_val_q  <= slot_val_d;
    slot_size_q <= slot_size_d;
    waddr_q     <= waddr_d;
    wval_q      <= wval_d;
    wsize_q     <= wsize_d;
  end

  assign req_ready   = ~pending_q;
  assign mem_we      = (state_q == WRITE);
  assign mem_addr    = mem_we ? (waddr_q + ADDR_W'(k_q)) : '0;
  assign mem_wdata   = mem_we ? 8'(wval_q >> {byte_sel, 3'b000}) : 8'h00;
  assign busy        = (state_q != IDLE) || (|pending_q);
  assign patch_done  = (state_q == DONE);
  assign patch_count = count_q;
  assign err_size    = err_q;

endmodule
